// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// cache-miss freezes, and saturating performance counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       iRs_RegF,
  input  logic [4:0]       iRt_RegF,
  input  logic             iUseRt_RegF,
  input  logic             iMemRead_RegD,
  input  logic [4:0]       iwsel_RegD,
  input  logic             iBranchTaken_E,
  input  logic             iICache_stall,
  input  logic             iDCache_stall,
  input  logic             iCntClr,
  output logic             oPC_Stall,
  output logic             oIFID_Stall,
  output logic             oIFID_Flush,
  output logic             oIDEX_Stall,
  output logic             oIDEX_Flush,
  output logic             oEXMEM_Stall,
  output logic             oMEMWB_Stall,
  output logic [CNT_W-1:0] oStallCycles,
  output logic [CNT_W-1:0] oBubbleCnt,
  output logic [CNT_W-1:0] oFlushCnt
);

  typedef enum logic [1:0] {RUN, LU, FREEZE} state_t;

  state_t state, nextState;
  logic   pendFlush, nextPend;
  logic   freeze, loadUse;
  logic   doFreeze, doFlush, doBubble;

  assign freeze  = iICache_stall | iDCache_stall;
  assign loadUse = iMemRead_RegD & (iwsel_RegD != 5'd0) &
                   ((iRs_RegF == iwsel_RegD) | (iUseRt_RegF & (iRt_RegF == iwsel_RegD)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pendFlush <= 1'b0;
    end else begin
      state     <= nextState;
      pendFlush <= nextPend;
    end
  end

  // RUN and the freeze-release cycle share one priority chain; pendFlush is only ever set in FREEZE.
  always_comb begin
    doFreeze  = 1'b0;
    doFlush   = 1'b0;
    doBubble  = 1'b0;
    nextState = state;
    nextPend  = pendFlush;
    case (state)
      RUN, FREEZE: begin
        if (freeze) begin
          doFreeze  = 1'b1;
          nextState = FREEZE;
          nextPend  = pendFlush | iBranchTaken_E;
        end else if (iBranchTaken_E || pendFlush) begin
          doFlush   = 1'b1;
          nextState = RUN;
          nextPend  = 1'b0;
        end else if (loadUse) begin
          doBubble  = 1'b1;
          nextState = LU;
        end else begin
          nextState = RUN;
        end
      end
      LU: nextState = freeze ? FREEZE : RUN;
      default: begin
        nextState = RUN;
        nextPend  = 1'b0;
      end
    endcase
  end

  assign oPC_Stall    = rst_n & (doFreeze | doBubble);
  assign oIFID_Stall  = rst_n & (doFreeze | doBubble);
  assign oIFID_Flush  = rst_n & doFlush;
  assign oIDEX_Stall  = rst_n & doFreeze;
  assign oIDEX_Flush  = rst_n & (doFlush | doBubble);
  assign oEXMEM_Stall = rst_n & doFreeze;
  assign oMEMWB_Stall = rst_n & doFreeze;

  // Counters stick at all-ones; a clear in the same cycle beats any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oStallCycles <= '0;
      oBubbleCnt   <= '0;
      oFlushCnt    <= '0;
    end else if (iCntClr) begin
      oStallCycles <= '0;
      oBubbleCnt   <= '0;
      oFlushCnt    <= '0;
    end else begin
      if (doFreeze && (oStallCycles != '1)) oStallCycles <= oStallCycles + CNT_W'(1);
      if (doBubble && (oBubbleCnt != '1))   oBubbleCnt   <= oBubbleCnt + CNT_W'(1);
      if (doFlush && (oFlushCnt != '1))     oFlushCnt    <= oFlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected output vectors are queued as each cycle is driven
// and popped once the combinational response has settled; counters run narrow to reach saturation.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ  = 7'b1101011;
  localparam logic [6:0] FLSH = 7'b0010100;
  localparam logic [6:0] BUB  = 7'b1100100;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRt;
    logic       memRead;
    logic [4:0] wsel;
    logic       br;
    logic       ic;
    logic       dc;
    logic       clr;
    logic [6:0] exp;
  } row_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] iRs_RegF, iRt_RegF, iwsel_RegD;
  logic iUseRt_RegF, iMemRead_RegD, iBranchTaken_E, iICache_stall, iDCache_stall, iCntClr;
  logic oPC_Stall, oIFID_Stall, oIFID_Flush, oIDEX_Stall, oIDEX_Flush, oEXMEM_Stall, oMEMWB_Stall;
  logic [CNT_W-1:0] oStallCycles, oBubbleCnt, oFlushCnt;
  wire  [6:0] outs = {oPC_Stall, oIFID_Stall, oIFID_Flush, oIDEX_Stall, oIDEX_Flush,
                      oEXMEM_Stall, oMEMWB_Stall};

  logic [6:0] expQ[$];
  logic [6:0] expOut;
  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .iRs_RegF(iRs_RegF), .iRt_RegF(iRt_RegF), .iUseRt_RegF(iUseRt_RegF),
    .iMemRead_RegD(iMemRead_RegD), .iwsel_RegD(iwsel_RegD),
    .iBranchTaken_E(iBranchTaken_E), .iICache_stall(iICache_stall),
    .iDCache_stall(iDCache_stall), .iCntClr(iCntClr),
    .oPC_Stall(oPC_Stall), .oIFID_Stall(oIFID_Stall), .oIFID_Flush(oIFID_Flush),
    .oIDEX_Stall(oIDEX_Stall), .oIDEX_Flush(oIDEX_Flush),
    .oEXMEM_Stall(oEXMEM_Stall), .oMEMWB_Stall(oMEMWB_Stall),
    .oStallCycles(oStallCycles), .oBubbleCnt(oBubbleCnt), .oFlushCnt(oFlushCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic row_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic useRt,
                              input logic memRead, input logic [4:0] wsel, input logic br,
                              input logic ic, input logic dc, input logic clr,
                              input logic [6:0] exp);
    row_t r;
    r = {rs, rt, useRt, memRead, wsel, br, ic, dc, clr, exp};
    return r;
  endfunction

  function automatic row_t zeroRow(input logic [6:0] exp);
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
  endfunction

  function automatic row_t luRow(input logic br, input logic clr, input logic [6:0] exp);
    return mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, br, 1'b0, 1'b0, clr, exp);
  endfunction

  function automatic row_t dcRow(input logic br, input logic [6:0] exp);
    return mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, br, 1'b0, 1'b1, 1'b0, exp);
  endfunction

  task automatic applyStimulus(input row_t r);
    iRs_RegF       = r.rs;
    iRt_RegF       = r.rt;
    iUseRt_RegF    = r.useRt;
    iMemRead_RegD  = r.memRead;
    iwsel_RegD     = r.wsel;
    iBranchTaken_E = r.br;
    iICache_stall  = r.ic;
    iDCache_stall  = r.dc;
    iCntClr        = r.clr;
    expQ.push_back(r.exp);
  endtask

  task automatic test_reset;
    row_t rows[$];
    rst_n = 1'b0;
    rows.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, NONE));
    rows.push_back(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL reset row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if ({oStallCycles, oBubbleCnt, oFlushCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset counters: got %0d/%0d/%0d, expected 0/0/0",
               oStallCycles, oBubbleCnt, oFlushCnt);
    end
    applyStimulus(zeroRow(NONE));
    void'(expQ.pop_front());
    rst_n = 1'b1;
  endtask

  task automatic test_load_use;
    row_t rows[$];
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(luRow(1'b0, 1'b0, NONE));
    rows.push_back(zeroRow(NONE));
    rows.push_back(mk(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, BUB));
    rows.push_back(zeroRow(NONE));
    rows.push_back(mk(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    rows.push_back(mk(5'd7, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    rows.push_back(mk(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL load_use row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oBubbleCnt !== 4'd2 || oFlushCnt !== 4'd0 || oStallCycles !== 4'd0) begin
      errors++;
      $display("[TB] FAIL load_use counters: bubble/flush/stall %0d/%0d/%0d, expected 2/0/0",
               oBubbleCnt, oFlushCnt, oStallCycles);
    end
  endtask

  task automatic test_zero_reg;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    rows.push_back(mk(5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL zero_reg row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oBubbleCnt !== 4'd2) begin
      errors++;
      $display("[TB] FAIL zero_reg bubble count: got %0d, expected 2", oBubbleCnt);
    end
  endtask

  task automatic test_branch_priority;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE));
    rows.push_back(luRow(1'b1, 1'b0, FLSH));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL branch_priority row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oFlushCnt !== 4'd1 || oBubbleCnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL branch_priority counters: flush/bubble %0d/%0d, expected 1/0",
               oFlushCnt, oBubbleCnt);
    end
  endtask

  task automatic test_freeze_branch;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE));
    rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(dcRow(1'b1, FRZ));
    rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(zeroRow(FLSH));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL freeze_branch row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oStallCycles !== 4'd5 || oFlushCnt !== 4'd1) begin
      errors++;
      $display("[TB] FAIL freeze_branch counters: stall/flush %0d/%0d, expected 5/1",
               oStallCycles, oFlushCnt);
    end
  endtask

  task automatic test_freeze_release;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE));
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ));
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, FRZ));
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(luRow(1'b0, 1'b0, NONE));
    rows.push_back(zeroRow(NONE));
    rows.push_back(dcRow(1'b1, FRZ));
    rows.push_back(zeroRow(FLSH));
    rows.push_back(zeroRow(NONE));
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(dcRow(1'b0, NONE));
    rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL freeze_release row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oStallCycles !== 4'd4 || oFlushCnt !== 4'd1 || oBubbleCnt !== 4'd2) begin
      errors++;
      $display("[TB] FAIL freeze_release counters: stall/flush/bubble %0d/%0d/%0d, expected 4/1/2",
               oStallCycles, oFlushCnt, oBubbleCnt);
    end
  endtask

  task automatic test_reset_mid_freeze;
    row_t rows[$];
    applyStimulus(dcRow(1'b1, FRZ));
    #2;
    expOut = expQ.pop_front();
    checks++;
    if (outs !== expOut) begin
      errors++;
      $display("[TB] FAIL reset_mid_freeze entry: outputs %b, expected %b", outs, expOut);
    end
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(dcRow(1'b0, NONE));
    #1;
    expOut = expQ.pop_front();
    checks++;
    if (outs !== expOut) begin
      errors++;
      $display("[TB] FAIL reset_mid_freeze in reset: outputs %b, expected %b", outs, expOut);
    end
    checks++;
    if ({oStallCycles, oBubbleCnt, oFlushCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_freeze counters: %0d/%0d/%0d, expected 0/0/0",
               oStallCycles, oBubbleCnt, oFlushCnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rows.push_back(zeroRow(NONE));
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL reset_mid_freeze row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oFlushCnt !== 4'd0 || oBubbleCnt !== 4'd1) begin
      errors++;
      $display("[TB] FAIL reset_mid_freeze after release: flush/bubble %0d/%0d, expected 0/1",
               oFlushCnt, oBubbleCnt);
    end
  endtask

  task automatic test_saturation;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE));
    for (int k = 0; k < 17; k++) begin
      rows.push_back(luRow(1'b0, 1'b0, BUB));
      rows.push_back(zeroRow(NONE));
    end
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL saturation row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oBubbleCnt !== 4'd15) begin
      errors++;
      $display("[TB] FAIL saturation bubble count: got %0d, expected 15", oBubbleCnt);
    end
    rows.delete();
    rows.push_back(luRow(1'b0, 1'b1, BUB));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL clear_vs_inc row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oBubbleCnt !== 4'd0) begin
      errors++;
      $display("[TB] FAIL clear_vs_inc bubble count: got %0d, expected 0", oBubbleCnt);
    end
    rows.delete();
    for (int k = 0; k < 18; k++) rows.push_back(dcRow(1'b0, FRZ));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL stall_saturation row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oStallCycles !== 4'd15) begin
      errors++;
      $display("[TB] FAIL stall_saturation count: got %0d, expected 15", oStallCycles);
    end
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, NONE));
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, FLSH));
    rows.push_back(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, FLSH));
    rows.push_back(luRow(1'b1, 1'b0, FLSH));
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(luRow(1'b0, 1'b0, NONE));
    rows.push_back(luRow(1'b0, 1'b0, BUB));
    rows.push_back(zeroRow(NONE));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #2;
      expOut = expQ.pop_front();
      checks++;
      if (outs !== expOut) begin
        errors++;
        $display("[TB] FAIL back_to_back row %0d: outputs %b, expected %b", i, outs, expOut);
      end
      @(negedge clk);
    end
    checks++;
    if (oFlushCnt !== 4'd3 || oBubbleCnt !== 4'd2) begin
      errors++;
      $display("[TB] FAIL back_to_back counters: flush/bubble %0d/%0d, expected 3/2",
               oFlushCnt, oBubbleCnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch_priority();
    test_freeze_branch();
    test_freeze_release();
    test_reset_mid_freeze();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
